// File: rtl/ann_pkg.sv
// Shared definitions for the LVI-PDNN solver: monitor FSM encoding
// and the fixed-point word format used by the network core.
package ann_pkg;

    localparam int DW_DEF    = 32;
    localparam int FRAC_BITS = 16;
    localparam int INT_BITS  = DW_DEF - FRAC_BITS;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_HOLD = 2'd2;

endpackage

// File: rtl/ann_abs_diff.sv
// |a-b| of two signed words, widened by one bit so the
// magnitude can never overflow, plus a <= threshold flag.
import ann_pkg::*;

module ann_abs_diff #(
    parameter int DW = DW_DEF
) (
    input  logic signed [DW-1:0] a_i,
    input  logic signed [DW-1:0] b_i,
    input  logic        [DW:0]   thr_i,
    output logic        [DW:0]   abs_o,
    output logic                 le_eps_o
);

    logic signed [DW:0] d;

    assign d        = {a_i[DW-1], a_i} - {b_i[DW-1], b_i};
    assign abs_o    = d[DW] ? -d : d;
    assign le_eps_o = (abs_o <= thr_i);

endmodule

// File: rtl/ann_conv_monitor.sv
// Drives the network enable, watches per-step state deltas and
// latches the QP solution on convergence or iteration timeout.
import ann_pkg::*;

module ann_conv_monitor #(
    parameter int DW         = DW_DEF,
    parameter int EPS        = 64,
    parameter int STABLE_CNT = 8,
    parameter int ITW        = 16,
    parameter int MAX_ITER   = 65535
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 sample,
    input  logic signed [DW-1:0] x1,
    input  logic signed [DW-1:0] x2,
    input  logic signed [DW-1:0] u,
    input  logic signed [DW-1:0] v,
    output logic                 net_en,
    output logic                 busy,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic        [DW-1:0] res_x1,
    output logic        [DW-1:0] res_x2,
    output logic        [DW-1:0] res_u,
    output logic        [DW-1:0] res_v,
    output logic       [ITW-1:0] res_iter,
    output logic                 res_conv
);

    localparam int SW = $clog2(STABLE_CNT + 1);
    localparam logic [DW:0]    EPS_W = (DW+1)'(EPS);
    localparam logic [SW-1:0]  SC_W  = SW'(STABLE_CNT);
    localparam logic [ITW-1:0] MI_W  = ITW'(MAX_ITER);

    state_t               state_q, state_d;
    logic                 first_q, first_d;
    logic [ITW-1:0]       iter_q, iter_d, iter_inc;
    logic [SW-1:0]        stable_q, stable_d, stable_inc;
    logic [3:0][DW-1:0]   cur, prev_q, prev_d, res_q, res_d;
    logic [ITW-1:0]       res_iter_q, res_iter_d;
    logic                 res_conv_q, res_conv_d;
    logic [3:0]           le;
    logic [3:0][DW:0]     dmag_unused;
    logic                 all_ok, conv_hit, time_hit;

    assign cur = {v, u, x2, x1};

    for (genvar i = 0; i < 4; i++) begin : g_ad
        ann_abs_diff #(.DW(DW)) u_ad (
            .a_i      (cur[i]),
            .b_i      (prev_q[i]),
            .thr_i    (EPS_W),
            .abs_o    (dmag_unused[i]),
            .le_eps_o (le[i])
        );
    end

    always_comb begin
        all_ok     = &le;
        iter_inc   = first_q ? ITW'(1) : iter_q + ITW'(1);
        stable_inc = '0;
        if (!first_q && all_ok) begin
            stable_inc = (stable_q == SC_W) ? stable_q
                                            : stable_q + SW'(1);
        end
        conv_hit = !first_q && (stable_inc == SC_W);
        time_hit = (iter_inc == MI_W);

        state_d    = state_q;
        first_d    = first_q;
        iter_d     = iter_q;
        stable_d   = stable_q;
        prev_d     = prev_q;
        res_d      = res_q;
        res_iter_d = res_iter_q;
        res_conv_d = res_conv_q;

        unique case (1'b1)
            state_q == ST_IDLE: begin
                if (start) begin
                    state_d  = ST_RUN;
                    first_d  = 1'b1;
                    iter_d   = '0;
                    stable_d = '0;
                end
            end
            state_q == ST_RUN: begin
                // abort outranks a terminating sample
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (sample) begin
                    first_d  = 1'b0;
                    iter_d   = iter_inc;
                    stable_d = stable_inc;
                    prev_d   = cur;
                    if (conv_hit || time_hit) begin
                        state_d    = ST_HOLD;
                        res_d      = cur;
                        res_iter_d = iter_inc;
                        res_conv_d = conv_hit;
                    end
                end
            end
            state_q == ST_HOLD: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            first_q    <= 1'b1;
            iter_q     <= '0;
            stable_q   <= '0;
            prev_q     <= '0;
            res_q      <= '0;
            res_iter_q <= '0;
            res_conv_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            first_q    <= first_d;
            iter_q     <= iter_d;
            stable_q   <= stable_d;
            prev_q     <= prev_d;
            res_q      <= res_d;
            res_iter_q <= res_iter_d;
            res_conv_q <= res_conv_d;
        end
    end

    assign net_en    = (state_q == ST_RUN);
    assign busy      = (state_q != ST_IDLE);
    assign res_valid = (state_q == ST_HOLD);
    assign res_x1    = res_q[0];
    assign res_x2    = res_q[1];
    assign res_u     = res_q[2];
    assign res_v     = res_q[3];
    assign res_iter  = res_iter_q;
    assign res_conv  = res_conv_q;

endmodule

// File: doc/ann_conv_monitor.md
Name: ann_conv_monitor

Overview:
- Sits directly downstream of the LVI-PDNN network core and drives that core's enable input (`en`).
- Samples the core's state outputs (x1, x2, u, v) once per completed integration step.
- Declares convergence when every state component changes by no more than EPS for STABLE_CNT consecutive steps; declares timeout after MAX_ITER steps.
- Latches the final QP solution and hands it to the host side over a valid/ready handshake.

Parameters:
- DW, 32, width of each signed fixed-point state word.
- EPS, 64, convergence threshold on |delta| per step, in the network's fixed-point LSBs (unsigned).
- STABLE_CNT, 8, number of consecutive sub-threshold steps required to declare convergence (>=1).
- ITW, 16, width of the iteration counter.
- MAX_ITER, 65535, iteration limit; must be <= 2^ITW-1.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse; begins a solve when idle
- abort  input  1  one-cycle pulse; cancels a running solve
- sample  input  1  pulse; the network integrators updated this cycle and x1/x2/u/v are valid
- x1  input  DW  network state x1 (signed)
- x2  input  DW  network state x2 (signed)
- u  input  DW  network state u (signed)
- v  input  DW  network state v (signed)
- net_en  output  1  enable to the network core; high only while running
- busy  output  1  high in RUN and HOLD
- res_valid  output  1  result available
- res_ready  input  1  consumer accepts result
- res_x1  output  DW  latched result for x1
- res_x2  output  DW  latched result for x2
- res_u  output  DW  latched result for u
- res_v  output  DW  latched result for v
- res_iter  output  ITW  step count at termination
- res_conv  output  1  1 = converged, 0 = timeout

Behaviour:
- Reset (async, reset=0):
  - State goes to IDLE.
  - All outputs are 0; prev registers, iter and stable counters are 0; first_flag is 1.
- FSM states: IDLE, RUN, HOLD.
- IDLE:
  - start=1 -> RUN next cycle. Clear iter and stable, set first_flag.
  - sample and abort are ignored in IDLE, including a sample that coincides with start.
- RUN:
  - net_en=1 and busy=1, both registered.
  - On each sample with first_flag=1: capture prev<=current, clear first_flag, iter<=1. No comparison is made.
  - On each sample with first_flag=0:
    - Increment iter.
    - For each channel, compute d = sign-extended (DW+1)-bit difference current-prev. |d| must not overflow; compare |d| <= EPS.
    - If all four channels pass, stable increments (saturating at STABLE_CNT); otherwise stable clears.
    - prev <= current.
  - Convergence: the incremented stable equals STABLE_CNT -> HOLD with res_conv=1.
  - Timeout: the incremented iter equals MAX_ITER and convergence is not met -> HOLD with res_conv=0.
  - Convergence has priority when both occur on the same sample.
  - On entry to HOLD:
    - res_x1, res_x2, res_u, res_v <= the current sample values.
    - res_iter <= the incremented iter.
    - net_en drops the cycle after the terminating sample.
    - res_valid rises on that same cycle (latency 1 clk).
  - abort=1 -> IDLE next cycle, net_en low, no result. abort wins over a simultaneous terminating sample.
- HOLD:
  - res_valid=1; all res_* hold stable until the handshake.
  - res_valid && res_ready -> IDLE next cycle and res_valid clears.
  - res_* keep their values after the handshake until the next HOLD entry.
  - start and abort are ignored in HOLD.
- start in RUN or HOLD is ignored.
- Reset mid-operation: immediate return to IDLE, outputs cleared, any pending result discarded.
- Counters never wrap; iter cannot exceed MAX_ITER.

Decomposition:
- Shared package ann_pkg: state enum (IDLE/RUN/HOLD), DW default, fixed-point format constants shared with the network core.
- One sub-module: ann_abs_diff (combinational). Inputs are two signed DW values; outputs are the unsigned DW+1-bit |a-b| and an le_eps flag against a threshold input. Instantiated four times.

Test Plan:
- Convergence: start, then samples x1=1000,1000,1010,1005,... all deltas <=64 on every channel for 9 samples (first plus 8) -> res_valid 1 clk after the 9th sample; res_conv=1, res_iter=9, res_* = 9th-sample values, net_en low.
- Stability reset: deltas 10,10,10,200,10... on x2 -> stable clears at the delta=200 sample; converges only after 8 further good samples; res_iter=13 for 13 samples.
- Timeout: MAX_ITER=20, deltas alternating 0/100 on v -> res_conv=0, res_iter=20.
- Priority and edge: MAX_ITER=9 with all deltas 0 -> convergence and timeout on the same sample give res_conv=1. Deltas of exactly 64 and -64 count as stable. x1 going 0x7FFFFFFF -> 0x80000000 has delta > EPS with no overflow misclassification.
- Handshake: hold res_ready=0 for 5 cycles -> res_valid and res_* stable, start pulses ignored. Raise res_ready -> IDLE next cycle; a new start is accepted.
- Abort/reset: abort on the same cycle as the terminating sample -> IDLE, res_valid never asserts. reset=0 asserted in RUN -> net_en and busy drop immediately (async).
